// File: rtl/xadc_drp_sampler.sv
// DRP read engine for the XADC event-driven sequencer: on each eoc it reads the converted
// channel's result, optionally boxcar-averages it per channel, and publishes it on a stream and a bank.
module xadc_drp_sampler #(
   parameter  int NUM_CH   = 4,
   parameter  int CH_BASE  = 21,
   parameter  int DATA_W   = 12,
   parameter  int AVG_LOG2 = 0,
   parameter  int TIMEOUT  = 31,
   localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     eoc_in,
   input  logic [4:0]               channel_in,
   output logic                     den_out,
   output logic                     dwe_out,
   output logic [6:0]               daddr_out,
   output logic [15:0]              di_out,
   input  logic                     drdy_in,
   input  logic [15:0]              do_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         out_ch,
   output logic [DATA_W-1:0]        out_data,
   output logic [NUM_CH*DATA_W-1:0] latest_data,
   output logic                     overrun,
   output logic                     missed,
   output logic                     timeout_err
);

   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                     state_q, state_d;
   logic [TMR_W-1:0]           timer_q;
   logic [IDX_W-1:0]           idx_q;
   logic                       den_q;
   logic [6:0]                 daddr_q;
   logic [ACC_W-1:0]           acc_q [NUM_CH];
   logic [CNT_W-1:0]           cnt_q [NUM_CH];
   logic                       out_valid_q;
   logic [IDX_W-1:0]           out_ch_q;
   logic [DATA_W-1:0]          out_data_q;
   logic [NUM_CH*DATA_W-1:0]   latest_q;
   logic                       overrun_q;

   logic                       in_range, start, capture, emit;
   logic [DATA_W-1:0]          sample;
   logic [ACC_W-1:0]           sum;
   logic [DATA_W-1:0]          avg;
   logic                       do_unused;

   assign in_range = (6'(channel_in) >= 6'(CH_BASE)) && (6'(channel_in) < 6'(CH_BASE + NUM_CH));
   assign sample   = do_in[15 -: DATA_W];
   assign sum      = acc_q[idx_q] + ACC_W'(sample);
   assign avg      = DATA_W'(sum >> AVG_LOG2);
   assign emit     = capture && (cnt_q[idx_q] == CNT_LAST);
   assign do_unused = ^do_in;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (eoc_in && in_range) state_d = WAIT;
         WAIT: if (drdy_in || timer_q == TMR_W'(TIMEOUT)) state_d = IDLE;
      endcase
   end

   // drdy wins over the timeout when both land on the final cycle
   always_comb begin
      start       = 1'b0;
      capture     = 1'b0;
      missed      = 1'b0;
      timeout_err = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: start = eoc_in && in_range;
            WAIT: begin
               capture     = drdy_in;
               missed      = eoc_in;
               timeout_err = !drdy_in && (timer_q == TMR_W'(TIMEOUT));
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         den_q       <= 1'b0;
         daddr_q     <= '0;
         idx_q       <= '0;
         timer_q     <= '0;
         acc_q       <= '{default: '0};
         cnt_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         latest_q    <= '0;
         overrun_q   <= 1'b0;
      end else begin
         den_q     <= start;
         overrun_q <= 1'b0;
         if (start) begin
            daddr_q <= {2'b00, channel_in};
            idx_q   <= IDX_W'(5'(channel_in - 5'(CH_BASE)));
            timer_q <= '0;
         end else if (state_q == WAIT) begin
            timer_q <= timer_q + TMR_W'(1);
         end
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         if (capture) begin
            if (emit) begin
               acc_q[idx_q] <= '0;
               cnt_q[idx_q] <= '0;
               latest_q[idx_q*DATA_W +: DATA_W] <= avg;
               if (!out_valid_q || out_ready) begin
                  out_valid_q <= 1'b1;
                  out_ch_q    <= idx_q;
                  out_data_q  <= avg;
               end else begin
                  overrun_q <= 1'b1;
               end
            end else begin
               acc_q[idx_q] <= sum;
               cnt_q[idx_q] <= cnt_q[idx_q] + CNT_W'(1);
            end
         end
      end
   end

   assign den_out     = den_q;
   assign dwe_out     = 1'b0;
   assign di_out      = '0;
   assign daddr_out   = daddr_q;
   assign out_valid   = out_valid_q;
   assign out_ch      = out_ch_q;
   assign out_data    = out_data_q;
   assign latest_data = latest_q;
   assign overrun     = overrun_q;

endmodule
